// File: rtl/tristan_bus_pkg.sv
// Shared bus-bridge definitions: the OBI-to-Wishbone FSM encoding and the Wishbone byte-select width.
package tristan_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } obi_wb_state_e;

  localparam int unsigned WB_SEL_W = 4;

endpackage

// File: rtl/obi_wb_bridge.sv
// OBI data port to Wishbone B4 classic master bridge. It allows one outstanding access,
// and a bus watchdog turns a hung slave into an OBI error response.
module obi_wb_bridge
  import tristan_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  obi_req_i,
  output logic                  obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0] obi_addr_i,
  input  logic                  obi_we_i,
  input  logic [WB_SEL_W-1:0]   obi_be_i,
  input  logic [31:0]           obi_wdata_i,
  output logic                  obi_rvalid_o,
  output logic [31:0]           obi_rdata_o,
  output logic                  obi_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [WB_SEL_W-1:0]   wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  // A width of 1 is kept when the watchdog is disabled, so that the counter is never zero-width.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  obi_wb_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic             handshake;

  // The grant depends only on the request and the FSM state, never on WB inputs.
  assign obi_gnt_o = obi_req_i && (state == IDLE || state == RESP);
  assign handshake = obi_req_i && obi_gnt_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= '0;
      wb_dat_o     <= '0;
      obi_rvalid_o <= 1'b0;
      obi_rdata_o  <= '0;
      obi_err_o    <= 1'b0;
    end else begin
      obi_rvalid_o <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (handshake) begin
            state    <= BUS;
            cnt      <= '0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= obi_we_i;
            wb_adr_o <= {obi_addr_i[ADDR_WIDTH-1:2], 2'b00};
            wb_sel_o <= obi_be_i;
            wb_dat_o <= obi_wdata_i;
          end else begin
            state <= IDLE;
          end
        end
        BUS: begin
          if (wb_err_i || (!wb_ack_i && WDOG_EN && cnt == CNT_LAST)) begin
            state        <= RESP;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            obi_rvalid_o <= 1'b1;
            obi_err_o    <= 1'b1;
            obi_rdata_o  <= '0;
          end else if (wb_ack_i) begin
            state        <= RESP;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            obi_rvalid_o <= 1'b1;
            obi_err_o    <= 1'b0;
            obi_rdata_o  <= wb_we_o ? '0 : wb_dat_i;
          end else if (WDOG_EN) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Directed test of obi_wb_bridge. Cycle k starts 1 time unit after the k-th rising edge
// of a test, and all outputs are checked in that window.
module tb_obi_wb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        cyc;
  logic        stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_wdat;
  logic [31:0] wb_rdat;
  logic        ack;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obi_wb_bridge #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .obi_req_i    (req),
    .obi_gnt_o    (gnt),
    .obi_addr_i   (addr),
    .obi_we_i     (we),
    .obi_be_i     (be),
    .obi_wdata_i  (wdata),
    .obi_rvalid_o (rvalid),
    .obi_rdata_o  (rdata),
    .obi_err_o    (err),
    .wb_cyc_o     (cyc),
    .wb_stb_o     (stb),
    .wb_we_o      (wb_we),
    .wb_adr_o     (wb_adr),
    .wb_sel_o     (wb_sel),
    .wb_dat_o     (wb_wdat),
    .wb_dat_i     (wb_rdat),
    .wb_ack_i     (ack),
    .wb_err_i     (wb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
    wb_rdat = '0; ack = 1'b0; wb_err = 1'b0;
    tick(); tick();
    check("rst_cyc", 32'(cyc), 0);
    check("rst_stb", 32'(stb), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_adr", wb_adr, 0);
    check("rst_dat", wb_wdat, 0);
    rst = 1'b0;
    tick();

    // Read with zero wait states
    req = 1'b1; addr = 32'h0220_0006; be = 4'b0100; we = 1'b0;
    #1 check("rd_gnt_c0", 32'(gnt), 1);
    tick();                                   // cycle 1
    req = 1'b0;
    check("rd_cyc_c1", 32'(cyc), 1);
    check("rd_stb_c1", 32'(stb), 1);
    check("rd_adr", wb_adr, 32'h0220_0004);
    check("rd_sel", 32'(wb_sel), 32'h4);
    check("rd_we", 32'(wb_we), 0);
    check("rd_rvalid_c1", 32'(rvalid), 0);
    ack = 1'b1; wb_rdat = 32'hDEADBEEF;
    tick();                                   // cycle 2
    ack = 1'b0; wb_rdat = '0;
    check("rd_rvalid_c2", 32'(rvalid), 1);
    check("rd_rdata", rdata, 32'hDEADBEEF);
    check("rd_err", 32'(err), 0);
    check("rd_cyc_c2", 32'(cyc), 0);
    tick();
    check("rd_rvalid_c3", 32'(rvalid), 0);

    // Write with three wait states
    req = 1'b1; addr = 32'h0000_1000; we = 1'b1; be = 4'hF; wdata = 32'h12345678;
    tick();                                   // cycle 1
    req = 1'b0; wdata = 32'hFFFF_0000; we = 1'b0; be = 4'h0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("wr_dat_c%0d", c), wb_wdat, 32'h12345678);
      check($sformatf("wr_cyc_c%0d", c), 32'(cyc), 1);
      check($sformatf("wr_we_c%0d", c), 32'(wb_we), 1);
      check($sformatf("wr_rvalid_c%0d", c), 32'(rvalid), 0);
      if (c == 4) begin
        ack = 1'b1; wb_rdat = 32'hCAFE_F00D;
      end
      tick();
    end
    ack = 1'b0;                               // cycle 5
    check("wr_rvalid_c5", 32'(rvalid), 1);
    check("wr_rdata", rdata, 0);
    check("wr_err", 32'(err), 0);
    check("wr_cyc_c5", 32'(cyc), 0);
    tick();

    // Back-to-back reads with req held high
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0000_0100;
    #1 check("b2b_gnt_c0", 32'(gnt), 1);
    tick();                                   // cycle 1
    check("b2b_gnt_c1", 32'(gnt), 0);
    check("b2b_adr_1", wb_adr, 32'h0000_0100);
    ack = 1'b1; wb_rdat = 32'h1111_1111; addr = 32'h0000_0204;
    tick();                                   // cycle 2
    ack = 1'b0;
    check("b2b_cyc_c2", 32'(cyc), 0);
    check("b2b_rvalid_c2", 32'(rvalid), 1);
    check("b2b_rdata_1", rdata, 32'h1111_1111);
    check("b2b_gnt_c2", 32'(gnt), 1);
    tick();                                   // cycle 3
    check("b2b_adr_2", wb_adr, 32'h0000_0204);
    check("b2b_rvalid_c3", 32'(rvalid), 0);
    ack = 1'b1; wb_rdat = 32'h2222_2222; addr = 32'h0000_030B;
    tick();                                   // cycle 4
    ack = 1'b0;
    check("b2b_cyc_c4", 32'(cyc), 0);
    check("b2b_rvalid_c4", 32'(rvalid), 1);
    check("b2b_rdata_2", rdata, 32'h2222_2222);
    check("b2b_gnt_c4", 32'(gnt), 1);
    tick();                                   // cycle 5
    req = 1'b0;
    check("b2b_adr_3", wb_adr, 32'h0000_0308);
    check("b2b_cyc_c5", 32'(cyc), 1);
    ack = 1'b1; wb_rdat = 32'h3333_3333;
    tick();                                   // cycle 6
    ack = 1'b0;
    check("b2b_rvalid_c6", 32'(rvalid), 1);
    check("b2b_rdata_3", rdata, 32'h3333_3333);
    tick();                                   // cycle 7
    check("b2b_rvalid_c7", 32'(rvalid), 0);
    check("b2b_cyc_c7", 32'(cyc), 0);

    // Error wins over a simultaneous ack
    req = 1'b1; addr = 32'h0000_0040;
    tick();
    req = 1'b0;
    ack = 1'b1; wb_err = 1'b1; wb_rdat = 32'hABCD_EF01;
    tick();
    ack = 1'b0; wb_err = 1'b0;
    check("prec_rvalid", 32'(rvalid), 1);
    check("prec_err", 32'(err), 1);
    check("prec_rdata", rdata, 0);
    tick();

    // Watchdog with a slave that never responds
    req = 1'b1; addr = 32'h0000_0080;
    tick();                                   // cycle 1
    req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("to_cyc_c%0d", c), 32'(cyc), 1);
      check($sformatf("to_rvalid_c%0d", c), 32'(rvalid), 0);
      tick();
    end
    check("to_cyc_c5", 32'(cyc), 0);          // cycle 5
    check("to_rvalid_c5", 32'(rvalid), 1);
    check("to_err_c5", 32'(err), 1);
    check("to_rdata_c5", rdata, 0);
    tick(); tick();                           // cycle 7
    ack = 1'b1; wb_rdat = 32'h5555_5555;
    tick();                                   // cycle 8
    ack = 1'b0;
    check("to_stray_rvalid", 32'(rvalid), 0);
    check("to_stray_cyc", 32'(cyc), 0);
    tick();

    // Reset during a waiting transaction
    req = 1'b1; addr = 32'h0000_00C0;
    tick();                                   // cycle 1
    req = 1'b0;
    check("rs_cyc_c1", 32'(cyc), 1);
    tick();                                   // cycle 2
    rst = 1'b1;
    tick();                                   // cycle 3
    rst = 1'b0;
    check("rs_cyc_c3", 32'(cyc), 0);
    check("rs_stb_c3", 32'(stb), 0);
    check("rs_rvalid_c3", 32'(rvalid), 0);
    req = 1'b1;
    #1 check("rs_gnt_c3", 32'(gnt), 1);
    req = 1'b0;
    ack = 1'b1; wb_rdat = 32'h7777_7777;
    tick();                                   // cycle 4
    ack = 1'b0;
    check("rs_late_rvalid", 32'(rvalid), 0);
    check("rs_late_cyc", 32'(cyc), 0);
    tick();
    check("rs_late_rvalid2", 32'(rvalid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench time limit exceeded");
  end

endmodule

// File: doc/obi_wb_bridge.md
Name: obi_wb_bridge

Overview:
- Converts the core's OBI data port into a Wishbone B4 classic master: data_req/gnt/rvalid/addr/be/we/wdata/rdata.
- Sits directly downstream of the core top, between the core and the SoC Wishbone interconnect.
- Allows one outstanding transaction and pipelines the next grant into the response cycle.
- A bus-watchdog timeout terminates hung slaves and returns an OBI error.

Parameters:
- TIMEOUT_CYCLES, 255: WB cycles to wait for ack/err before forcing an error; 0 disables the watchdog.
- ADDR_WIDTH, 32: width of the OBI and WB address.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- obi_req_i  in  1  OBI request
- obi_gnt_o  out  1  OBI grant, combinational
- obi_addr_i  in  ADDR_WIDTH  byte address
- obi_we_i  in  1  write enable
- obi_be_i  in  4  byte enables
- obi_wdata_i  in  32  write data
- obi_rvalid_o  out  1  response valid, one cycle per granted request
- obi_rdata_o  out  32  read data
- obi_err_o  out  1  response error, qualified by obi_rvalid_o
- wb_cyc_o  out  1  WB cycle
- wb_stb_o  out  1  WB strobe
- wb_we_o  out  1  WB write
- wb_adr_o  out  ADDR_WIDTH  WB address, word aligned
- wb_sel_o  out  4  WB byte select
- wb_dat_o  out  32  WB write data
- wb_dat_i  in  32  WB read data
- wb_ack_i  in  1  WB acknowledge
- wb_err_i  in  1  WB error

Behaviour:
- States: IDLE, BUS, RESP.
- Reset, synchronous active-high, on the clk_i edge:
  - state=IDLE, timeout counter=0.
  - All registered outputs 0: wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, obi_rvalid_o, obi_rdata_o, obi_err_o.
- Reset mid-transaction: cyc/stb drop at that edge and no rvalid is ever issued for the in-flight request. A late ack after reset is ignored.
- obi_gnt_o = obi_req_i && (state==IDLE || state==RESP). It is combinational with no dependence on WB inputs.
- Handshake (obi_req_i && obi_gnt_o) at edge N:
  - Register wb_adr_o={addr[ADDR_WIDTH-1:2],2'b00}, wb_sel_o=be, wb_we_o=we, wb_dat_o=wdata.
  - Set wb_cyc_o=wb_stb_o=1 and state=BUS.
  - Clear the counter.
- BUS, in priority order:
  - wb_err_i=1: drop cyc/stb, latch err=1 and rdata=0, go to RESP. wb_err_i wins over a simultaneous wb_ack_i.
  - Else wb_ack_i=1: drop cyc/stb, latch err=0 and rdata = wb_we_o ? 0 : wb_dat_i, go to RESP.
  - Else counter==TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES!=0: drop cyc/stb, latch err=1 and rdata=0, go to RESP.
  - Else increment the counter; cyc/stb and all WB outputs stay stable.
- RESP:
  - obi_rvalid_o=1 for exactly one cycle, with obi_rdata_o and obi_err_o valid.
  - If a new handshake occurs in this cycle, go directly to BUS with the new request. This gives back-to-back throughput of one transaction per 2 cycles plus the slave wait.
  - Otherwise go to IDLE.
- obi_rdata_o and obi_err_o hold their values until the next response; they are only meaningful with obi_rvalid_o.
- Latency: grant at cycle 0, WB strobe visible in cycle 1. A zero-wait ack in cycle 1 gives rvalid in cycle 2.
- ack or err while in IDLE or RESP (cyc low): ignored, no state change.
- obi_req_i dropped while not granted: legal, nothing issued.
- Counter width: $clog2(TIMEOUT_CYCLES+1). It never wraps because it is cleared on every grant.

Decomposition:
- Shared package tristan_bus_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUS, RESP} obi_wb_state_e
  - localparam WB_SEL_W=4
- No sub-module is required; the watchdog counter is inline.

Test Plan:
- Read, zero wait: req addr=0x0220_0006, be=4'b0100, we=0; slave ack in cycle 1 with dat=0xDEADBEEF.
  -> wb_adr_o=0x0220_0004, wb_sel_o=4'b0100; rvalid in cycle 2 with rdata=0xDEADBEEF, err=0.
- Write with 3 wait states: we=1, wdata=0x12345678, be=4'hF; ack in cycle 4.
  -> wb_dat_o stable 0x12345678 for cycles 1-4; rvalid in cycle 5 with rdata=0, err=0.
- Back-to-back: req held high for 3 reads, ack on first WB cycle each time.
  -> grants in cycles 0, 2 and 4; rvalid in cycles 2, 4 and 6; cyc low in cycles 2 and 4.
- Error precedence: ack=1 and err=1 in the same cycle.
  -> next cycle rvalid=1, err=1, rdata=0.
- Timeout with TIMEOUT_CYCLES=4 and a slave that never responds.
  -> cyc high for cycles 1-4, low in cycle 5, rvalid=1 and err=1 in cycle 5; a stray ack in cycle 7 is ignored.
- Reset asserted in cycle 2 of a waiting transaction.
  -> cycle 3: cyc=0, stb=0, rvalid=0, gnt available. An ack in cycle 3 produces no rvalid.
